// File: rtl/axi_rd_arb.sv
// axi_rd_arb: two-requester read arbiter in front of a single AXI-style read
// interface. One burst is outstanding at a time. Arbitration is round-robin
// when both requesters ask in the same cycle.
//
// Ports
//   clk, rst_n          : clock; rst_n is an asynchronous reset, active HIGH
//   rq<n>_ar*           : request from requester n (valid, addr, len, size, burst, str, id)
//   rq<n>_arrdy         : request accepted (combinational, IDLE only)
//   rq<n>_r*            : response beat routed to requester n, rq<n>_rrdy backpressure
//   arb_axi_ar*         : request to the read interface, axi_arb_arrdy accepts
//   axi_arb_r*          : response from the read interface, arb_axi_rrdy accepts
//   err_clr / err       : clear / sticky error (length mismatch or timeout)
//   busy / owner        : not idle / currently granted requester
module axi_rd_arb #(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rq0_arvld,
    input  logic [9:0]  rq0_araddr,
    input  logic [7:0]  rq0_arlen,
    input  logic [2:0]  rq0_arsize,
    input  logic [1:0]  rq0_arburst,
    input  logic [2:0]  rq0_arstr,
    input  logic [7:0]  rq0_arid,
    output logic        rq0_arrdy,
    output logic        rq0_rvld,
    output logic [63:0] rq0_rdata,
    output logic [1:0]  rq0_rresp,
    output logic        rq0_rlast,
    input  logic        rq0_rrdy,
    input  logic        rq1_arvld,
    input  logic [9:0]  rq1_araddr,
    input  logic [7:0]  rq1_arlen,
    input  logic [2:0]  rq1_arsize,
    input  logic [1:0]  rq1_arburst,
    input  logic [2:0]  rq1_arstr,
    input  logic [7:0]  rq1_arid,
    output logic        rq1_arrdy,
    output logic        rq1_rvld,
    output logic [63:0] rq1_rdata,
    output logic [1:0]  rq1_rresp,
    output logic        rq1_rlast,
    input  logic        rq1_rrdy,
    output logic        arb_axi_arvld,
    output logic [9:0]  arb_axi_araddr,
    output logic [7:0]  arb_axi_arlen,
    output logic [2:0]  arb_axi_arsize,
    output logic [1:0]  arb_axi_arburst,
    output logic [2:0]  arb_axi_arstr,
    output logic [7:0]  arb_axi_arid,
    input  logic        axi_arb_arrdy,
    input  logic        axi_arb_rvld,
    input  logic [63:0] axi_arb_rdata,
    input  logic [1:0]  axi_arb_rresp,
    input  logic        axi_arb_rlast,
    input  logic [7:0]  axi_arb_rid,
    output logic        arb_axi_rrdy,
    input  logic        err_clr,
    output logic        err,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t      state, state_nxt;
    logic        rr, rr_nxt;
    logic [8:0]  beat_cnt, beat_nxt, beat_inc;
    logic [7:0]  tmr, tmr_nxt;
    logic        err_set;
    logic        gnt_vld, gnt;
    logic        beat_hs;
    logic [9:0]  c_addr;
    logic [7:0]  c_len, c_id;
    logic [2:0]  c_size, c_str;
    logic [1:0]  c_burst;

    // Responses are steered by owner alone; the returned id carries no routing.
    logic unused_rid;
    assign unused_rid = ^axi_arb_rid;

    // Grant is combinational and only in IDLE; held off while reset is asserted
    // so no requester sees an accept during reset.
    always_comb begin
        gnt_vld = (state == IDLE) && !rst_n && (rq0_arvld || rq1_arvld);
        gnt     = (rq0_arvld && rq1_arvld) ? rr : rq1_arvld;
    end

    assign rq0_arrdy = gnt_vld && !gnt;
    assign rq1_arrdy = gnt_vld &&  gnt;
    assign beat_hs   = (state == DATA) && axi_arb_rvld && arb_axi_rrdy;
    assign beat_inc  = (beat_cnt == 9'd256) ? beat_cnt : beat_cnt + 9'd1;

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        beat_nxt  = beat_cnt;
        tmr_nxt   = tmr;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    state_nxt = ADDR;
                    tmr_nxt   = 8'd0;
                    beat_nxt  = 9'd0;
                end
            end
            ADDR: begin
                if (axi_arb_arrdy) begin
                    state_nxt = DATA;
                    tmr_nxt   = 8'd0;
                    beat_nxt  = 9'd0;
                end else if (tmr == TMO_LAST) begin
                    state_nxt = IDLE;
                    tmr_nxt   = 8'd0;
                    err_set   = 1'b1;
                    rr_nxt    = ~owner;
                end else begin
                    tmr_nxt = tmr + 8'd1;
                end
            end
            DATA: begin
                if (beat_hs) begin
                    tmr_nxt  = 8'd0;
                    beat_nxt = beat_inc;
                    if (axi_arb_rlast) begin
                        state_nxt = IDLE;
                        beat_nxt  = 9'd0;
                        rr_nxt    = ~owner;
                        err_set   = (beat_inc != {1'b0, c_len} + 9'd1);
                    end
                end else if (tmr == TMO_LAST) begin
                    state_nxt = IDLE;
                    tmr_nxt   = 8'd0;
                    beat_nxt  = 9'd0;
                    err_set   = 1'b1;
                    rr_nxt    = ~owner;
                end else begin
                    tmr_nxt = tmr + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= IDLE;
            rr       <= 1'b0;
            owner    <= 1'b0;
            beat_cnt <= 9'd0;
            tmr      <= 8'd0;
            err      <= 1'b0;
            c_addr   <= '0;
            c_len    <= '0;
            c_size   <= '0;
            c_burst  <= '0;
            c_str    <= '0;
            c_id     <= '0;
        end else begin
            state    <= state_nxt;
            rr       <= rr_nxt;
            beat_cnt <= beat_nxt;
            tmr      <= tmr_nxt;
            // set wins over a coincident clear
            err      <= err_set || (err && !err_clr);
            if (gnt_vld) begin
                owner   <= gnt;
                c_addr  <= gnt ? rq1_araddr  : rq0_araddr;
                c_len   <= gnt ? rq1_arlen   : rq0_arlen;
                c_size  <= gnt ? rq1_arsize  : rq0_arsize;
                c_burst <= gnt ? rq1_arburst : rq0_arburst;
                c_str   <= gnt ? rq1_arstr   : rq0_arstr;
                c_id    <= gnt ? rq1_arid    : rq0_arid;
            end
        end
    end

    assign busy            = (state != IDLE);
    assign arb_axi_arvld   = (state == ADDR);
    assign arb_axi_araddr  = c_addr;
    assign arb_axi_arlen   = c_len;
    assign arb_axi_arsize  = c_size;
    assign arb_axi_arburst = c_burst;
    assign arb_axi_arstr   = c_str;
    assign arb_axi_arid    = c_id;

    always_comb begin
        arb_axi_rrdy = 1'b0;
        rq0_rvld     = 1'b0;
        rq0_rdata    = '0;
        rq0_rresp    = '0;
        rq0_rlast    = 1'b0;
        rq1_rvld     = 1'b0;
        rq1_rdata    = '0;
        rq1_rresp    = '0;
        rq1_rlast    = 1'b0;
        if (state == DATA) begin
            if (owner) begin
                arb_axi_rrdy = rq1_rrdy;
                rq1_rvld     = axi_arb_rvld;
                rq1_rdata    = axi_arb_rdata;
                rq1_rresp    = axi_arb_rresp;
                rq1_rlast    = axi_arb_rlast;
            end else begin
                arb_axi_rrdy = rq0_rrdy;
                rq0_rvld     = axi_arb_rvld;
                rq0_rdata    = axi_arb_rdata;
                rq0_rresp    = axi_arb_rresp;
                rq0_rlast    = axi_arb_rlast;
            end
        end
    end

endmodule
